// File: rtl/uart_pkg.sv
// Shared UART definitions for tx_control and rx_control: widths, frame length,
// FSM state codes and parity-select encodings.
package uart_pkg;

  localparam int BAUD_W     = 20;
  localparam int FRAME_BITS = 11;
  localparam int BITCNT_W   = $clog2(FRAME_BITS + 1);

  typedef logic [0:0] state_t;
  localparam state_t IDLE  = 1'b0;
  localparam state_t SHIFT = 1'b1;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

endpackage

// File: rtl/uart_bit_timer.sv
// Baud and bit counter shared by the UART engines: btu marks the last clock of
// each bit-time, and done marks the btu that completes a full frame.
module uart_bit_timer
  import uart_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              run,
  input  logic [BAUD_W-1:0] baud,
  output logic              btu,
  output logic              done
);

  logic [BAUD_W-1:0]   count;
  logic [BAUD_W-1:0]   limit;
  logic [BITCNT_W-1:0] bitcnt;

  // A zero divisor would never produce a tick, so it behaves like a divisor of one.
  assign limit = (baud == '0) ? BAUD_W'(1) : baud;
  assign btu   = run && (count == limit - BAUD_W'(1));
  assign done  = btu && (bitcnt == BITCNT_W'(FRAME_BITS - 1));

  always_ff @(posedge clk) begin
    if (!reset || !run) begin
      count  <= '0;
      bitcnt <= '0;
    end else if (btu) begin
      count  <= '0;
      bitcnt <= done ? '0 : bitcnt + BITCNT_W'(1);
    end else begin
      count  <= count + BAUD_W'(1);
    end
  end

endmodule

// File: rtl/tx_control.sv
// UART transmit engine: latches a byte and its framing on load and shifts out an
// 11-bit-time frame, LSB first. Optional line break via macro TX_BREAK_EN.
module tx_control
  import uart_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [7:0]        out_port,
  input  logic              bit8,
  input  logic              pen,
  input  logic              ohel,
  input  logic [BAUD_W-1:0] baud,
  output logic              tx,
  output logic              tx_rdy
`ifdef TX_BREAK_EN
  ,
  input  logic              brk
`endif
);

  state_t                  state;
  logic                    pend;
  logic [FRAME_BITS-1:0]   shreg;
  logic [7:0]              data_h;
  logic                    bit8_h;
  logic                    pen_h;
  logic                    ohel_h;
  logic [BAUD_W-1:0]       baud_h;
  logic [7:0]              data_sent;
  logic                    pbit;
  logic [FRAME_BITS-1:0]   frame;
  logic                    btu;
  logic                    done;

  // d7 is masked off in 7-bit mode so it never affects parity.
  assign data_sent = bit8_h ? data_h : {1'b0, data_h[6:0]};
  assign pbit      = pen_h ? ((^data_sent) ^ (ohel_h == PAR_ODD)) : 1'b1;
  assign frame     = bit8_h ? {1'b1, pbit, data_h, 1'b0}
                            : {2'b11, pbit, data_h[6:0], 1'b0};

  assign tx = shreg[0];

  uart_bit_timer u_timer (
    .clk   (clk),
    .reset (reset),
    .run   (state == SHIFT),
    .baud  (baud_h),
    .btu   (btu),
    .done  (done)
  );

  // The load edge only captures the configuration; the frame enters the shift
  // register one clock later, which is where the start bit begins.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state  <= IDLE;
      pend   <= 1'b0;
      shreg  <= '1;
      tx_rdy <= 1'b1;
      data_h <= '0;
      bit8_h <= 1'b0;
      pen_h  <= 1'b0;
      ohel_h <= 1'b0;
      baud_h <= '0;
    end else if (state == IDLE) begin
      if (pend) begin
        pend  <= 1'b0;
        state <= SHIFT;
        shreg <= frame;
      end
`ifdef TX_BREAK_EN
      else if (brk) begin
        shreg  <= {{(FRAME_BITS-1){1'b1}}, 1'b0};
        tx_rdy <= 1'b0;
      end
`endif
      else if (load && tx_rdy) begin
        pend   <= 1'b1;
        tx_rdy <= 1'b0;
        data_h <= out_port;
        bit8_h <= bit8;
        pen_h  <= pen;
        ohel_h <= ohel;
        baud_h <= baud;
      end else begin
        shreg  <= '1;
        tx_rdy <= 1'b1;
      end
    end else begin
      if (done) begin
        state  <= IDLE;
        shreg  <= '1;
        tx_rdy <= 1'b1;
      end else if (btu) begin
        shreg <= {1'b1, shreg[FRAME_BITS-1:1]};
      end
    end
  end

endmodule

// File: tb/tb_tx_control.sv
// Self-checking bench for tx_control: directed frame table, a mid-frame reset
// sequence and randomized frames compared against a rule-based frame model.
module tb_tx_control;
  import uart_pkg::*;

  logic              clk = 1'b0;
  logic              reset;
  logic              load;
  logic [7:0]        out_port;
  logic              bit8;
  logic              pen;
  logic              ohel;
  logic [BAUD_W-1:0] baud;
  logic              tx;
  logic              tx_rdy;
`ifdef TX_BREAK_EN
  logic              brk = 1'b0;
`endif

  int assertCount = 0;
  int failCount   = 0;

  typedef struct {
    logic [7:0]  data;
    logic        b8;
    logic        pe;
    logic        od;
    int          bd;
    logic [10:0] expFrame;
    int          intrude;
  } vec_t;

  vec_t vecs[6];

  tx_control dut (
    .clk      (clk),
    .reset    (reset),
    .load     (load),
    .out_port (out_port),
    .bit8     (bit8),
    .pen      (pen),
    .ohel     (ohel),
    .baud     (baud),
    .tx       (tx),
    .tx_rdy   (tx_rdy)
`ifdef TX_BREAK_EN
    ,
    .brk      (brk)
`endif
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Frame built from the line rules: start 0, data LSB first, optional parity,
  // everything else 1. Index 0 is the first bit on the wire.
  function automatic logic [10:0] modelFrame(input logic [7:0] d, input logic b8,
                                             input logic pe, input logic od);
    logic [10:0] f;
    int n;
    int ones;
    int pos;
    f    = '1;
    f[0] = 1'b0;
    n    = b8 ? 8 : 7;
    ones = 0;
    pos  = 1;
    for (int i = 0; i < n; i++) begin
      f[pos] = d[i];
      ones   = ones + int'(d[i]);
      pos++;
    end
    if (pe)
      f[pos] = od ? ((ones % 2) == 0) : ((ones % 2) == 1);
    return f;
  endfunction

  task automatic applyStimulus(input logic [7:0] d, input logic b8, input logic pe,
                               input logic od, input int bd);
    out_port = d;
    bit8     = b8;
    pen      = pe;
    ohel     = od;
    baud     = BAUD_W'(bd);
    load     = 1'b1;
  endtask

  // Called right after applyStimulus; follows the frame cycle by cycle.
  task automatic runFrame(input string tag, input logic [10:0] expFrame, input int effBaud,
                          input bit scramble, input int intrudeCycle);
    logic bad;
    logic seen;
    int   cyc;
    tick();
    load = 1'b0;
    checkOutput({tag, " rdy fall"}, 32'(tx_rdy), 32'd0);
    checkOutput({tag, " line high before start"}, 32'(tx), 32'd1);
    tick();
    for (int b = 0; b < 11; b++) begin
      bad  = 1'b0;
      seen = expFrame[b];
      for (int c = 0; c < effBaud; c++) begin
        if (tx !== expFrame[b] || tx_rdy !== 1'b0) begin
          bad  = 1'b1;
          seen = tx;
        end
        cyc = b * effBaud + c;
        if (scramble) begin
          out_port = 8'($urandom);
          bit8     = 1'($urandom_range(0, 1));
          pen      = 1'($urandom_range(0, 1));
          ohel     = 1'($urandom_range(0, 1));
          baud     = BAUD_W'($urandom_range(0, 200));
        end
        if (cyc == intrudeCycle) begin
          load     = 1'b1;
          out_port = 8'h55;
        end else begin
          load = 1'b0;
        end
        tick();
      end
      checkOutput($sformatf("%s bit%0d {err,tx}", tag, b), 32'({bad, seen}), 32'({1'b0, expFrame[b]}));
    end
    load = 1'b0;
    checkOutput({tag, " rdy rise {tx,rdy}"}, 32'({tx, tx_rdy}), 32'b11);
    tick();
    checkOutput({tag, " idle after {tx,rdy}"}, 32'({tx, tx_rdy}), 32'b11);
  endtask

  initial begin
    logic        bad;
    logic [7:0]  d;
    logic        b8;
    logic        pe;
    logic        od;
    int          bd;
    int          eff;
    int          intr;

    // A5 8N1, 03 8E1, 03 8O1, FF 7O1, 80 7N1, 01 8O1 with baud 0.
    vecs[0] = '{8'hA5, 1'b1, 1'b0, 1'b0, 109, 11'h74A, 5 * 109};
    vecs[1] = '{8'h03, 1'b1, 1'b1, 1'b0, 7,   11'h406, 11 * 7 - 1};
    vecs[2] = '{8'h03, 1'b1, 1'b1, 1'b1, 3,   11'h606, -1};
    vecs[3] = '{8'hFF, 1'b0, 1'b1, 1'b1, 5,   11'h6FE, -1};
    vecs[4] = '{8'h80, 1'b0, 1'b0, 1'b0, 1,   11'h700, -1};
    vecs[5] = '{8'h01, 1'b1, 1'b1, 1'b1, 0,   11'h402, -1};

    reset    = 1'b0;
    load     = 1'b0;
    out_port = '0;
    bit8     = 1'b1;
    pen      = 1'b0;
    ohel     = 1'b0;
    baud     = BAUD_W'(109);
    tick();
    tick();
    checkOutput("reset tx", 32'(tx), 32'd1);
    checkOutput("reset tx_rdy", 32'(tx_rdy), 32'd1);
    reset = 1'b1;
    bad   = 1'b0;
    for (int c = 0; c < 200; c++) begin
      if (tx !== 1'b1 || tx_rdy !== 1'b1) bad = 1'b1;
      tick();
    end
    checkOutput("idle quiet after reset", 32'(bad), 32'd0);

    $display("[TB] directed frame table");
    for (int i = 0; i < 6; i++) begin
      eff = (vecs[i].bd == 0) ? 1 : vecs[i].bd;
      applyStimulus(vecs[i].data, vecs[i].b8, vecs[i].pe, vecs[i].od, vecs[i].bd);
      runFrame($sformatf("vec%0d", i), vecs[i].expFrame, eff, 1'b0, vecs[i].intrude);
    end

    $display("[TB] reset during data bit 4");
    applyStimulus(8'hA5, 1'b1, 1'b0, 1'b0, 4);
    tick();
    load = 1'b0;
    tick();
    for (int c = 0; c < 5 * 4 + 2; c++) tick();
    checkOutput("pre-reset data bit 4", 32'({tx, tx_rdy}), 32'b00);
    reset = 1'b0;
    tick();
    checkOutput("mid-frame reset {tx,rdy}", 32'({tx, tx_rdy}), 32'b11);
    reset = 1'b1;
    tick();
    checkOutput("after reset release {tx,rdy}", 32'({tx, tx_rdy}), 32'b11);
    applyStimulus(8'hA5, 1'b1, 1'b0, 1'b0, 4);
    runFrame("post-reset", modelFrame(8'hA5, 1'b1, 1'b0, 1'b0), 4, 1'b0, -1);

    $display("[TB] randomized frames");
    for (int i = 0; i < 24; i++) begin
      d    = 8'($urandom);
      b8   = 1'($urandom_range(0, 1));
      pe   = 1'($urandom_range(0, 1));
      od   = 1'($urandom_range(0, 1));
      bd   = $urandom_range(0, 6);
      eff  = (bd == 0) ? 1 : bd;
      intr = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 11 * eff - 1) : -1;
      applyStimulus(d, b8, pe, od, bd);
      runFrame($sformatf("rnd%0d d=%0h b8=%0d pe=%0d od=%0d bd=%0d", i, d, b8, pe, od, bd),
               modelFrame(d, b8, pe, od), eff, 1'b1, intr);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/tx_control.md
Name: tx_control

Overview:
- UART transmit engine: the transmit-side counterpart of rx_control on the same serial link.
- Serialises one byte per load into an 11-bit-time frame:
  - start bit
  - 7 or 8 data bits, LSB first
  - optional parity bit
  - stop/idle bits
- Uses the same runtime bit8/pen/baud configuration as the receiver.
- Sits between the PicoBlaze output-port decode (load strobe, out_port byte) and the tx pin.

Parameters:
- BAUD_W, 20, width of the baud bit-time count.
- FRAME_BITS, 11, bit-times per frame, including padding stop bits.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-low; effective at the rising clk edge where it is sampled 0.
- load  in  1  one-cycle strobe to start a frame; honoured only while tx_rdy=1.
- out_port  in  8  byte to transmit.
- bit8  in  1  1 = 8 data bits, 0 = 7 data bits.
- pen  in  1  parity enable.
- ohel  in  1  parity select: 1 = odd, 0 = even.
- baud  in  BAUD_W  clocks per bit-time (109 = fastest rate).
- tx  out  1  serial line, idle high.
- tx_rdy  out  1  engine idle and able to accept load.

Behaviour:
- Reset (reset=0 at an edge): tx=1, tx_rdy=1, counters cleared, state IDLE. Applies mid-frame too; the frame is abandoned and the line returns high on that edge.
- States: IDLE -> SHIFT -> IDLE.
- IDLE to SHIFT:
  - load=1 at edge k captures out_port, bit8, pen, ohel and baud into holding registers.
  - tx_rdy goes 0 at edge k.
  - The 11-bit shift register loads at edge k+1; tx=0 (start bit) from edge k+1.
  - Latency load-to-start-bit: 1 clock.
- Frame contents, LSB sent first, unused positions =1:
  - bit8=1, pen=1: 0, d0..d7, P, 1.
  - bit8=1, pen=0: 0, d0..d7, 1, 1.
  - bit8=0, pen=1: 0, d0..d6, P, 1, 1.
  - bit8=0, pen=0: 0, d0..d6, 1, 1, 1.
- Parity P:
  - Computed over the transmitted data bits only (d7 excluded when bit8=0).
  - even: P = XOR of those bits.
  - odd: P = ~XOR of those bits.
- Bit timing:
  - The baud counter counts 0..baud-1; btu is asserted on the cycle the count equals baud-1.
  - On btu the shift register shifts right (fill 1) and the bit counter increments.
  - Every bit lasts exactly baud clocks.
  - baud=0 is treated as 1.
- Frame end:
  - When the bit counter reaches FRAME_BITS on btu, the edge returns to IDLE with tx_rdy=1 and tx=1.
  - Total frame = 11*baud clocks from start-bit edge to tx_rdy rise.
- load while tx_rdy=0 (including the completion edge) is ignored; no queueing.
- Configuration inputs changing mid-frame have no effect; they were sampled at load.
- tx is registered with no combinational path from inputs.
- tx_rdy is registered.

Optional Feature:
- Macro: TX_BREAK_EN.
- Defined:
  - Adds port brk (in, 1).
  - While brk=1 and state IDLE: tx=0 and tx_rdy=0 from the next edge.
  - brk is ignored during SHIFT; the frame completes, then break takes effect.
  - Releasing brk returns tx=1 and tx_rdy=1 on the next edge.
- Undefined: no brk port; line is idle-high whenever not in SHIFT.

Decomposition:
- Package uart_pkg:
  - BAUD_W, FRAME_BITS.
  - State typedef {IDLE, SHIFT}.
  - Parity-select constants PAR_EVEN=0, PAR_ODD=1.
  - This package is shared with rx_control.
- One sub-module, uart_bit_timer:
  - Baud counter plus bit counter.
  - Inputs: clk, reset, run, baud.
  - Outputs: btu, done.
  - Reusable by rx_control.
- Frame assembly and parity stay in tx_control.

Test Plan:
- Idle reset: reset=0 two cycles then 1 → tx=1, tx_rdy=1, no activity for 2000 ns.
- 8N1, baud=109, 10 ns clk, load with out_port=8'hA5:
  - tx_rdy falls on the load edge.
  - tx=0 one clock later for 1090 ns, then bits 1,0,1,0,0,1,0,1,1,1 at 1090 ns each.
  - tx_rdy rises 11990 ns after the start edge.
- 8-bit even parity (bit8=1, pen=1, ohel=0), out_port=8'h03 → parity bit 0; repeat with ohel=1 → parity bit 1.
- 7-bit odd parity (bit8=0, pen=1, ohel=1), out_port=8'hFF:
  - d7 is not sent; 7 ones → P=0.
  - Frame 0,1111111,0,1,1.
- Load while busy: second load with 8'h55 at mid-frame → ignored; only 8'hA5 is seen on tx; tx_rdy stays low until frame end.
- Reset mid-frame: reset=0 during data bit 4 → tx=1, tx_rdy=1 on that edge; a new load afterwards transmits a clean full frame.
